// File: rtl/pc_control_if.sv
// Fetch-control bundle between the pipeline and pc_control.
// master = PC controller (drives fetch select/redirect), slave = pipeline side.
interface pc_control_if;
  logic        stall;
  logic [31:0] pc;
  logic        irq;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        eret;
  logic [1:0]  pc_sel;
  logic [31:0] pc_branch;
  logic        flush;
  logic [31:0] epc;
  logic        int_enable;
  logic        in_isr;

  modport master (
    input  stall, pc, irq, branch_taken, branch_target, eret,
    output pc_sel, pc_branch, flush, epc, int_enable, in_isr
  );

  modport slave (
    output stall, pc, irq, branch_taken, branch_target, eret,
    input  pc_sel, pc_branch, flush, epc, int_enable, in_isr
  );
endinterface

// File: rtl/pc_control.sv
// Fetch PC select / redirect / interrupt-entry controller.
// Latency: redirect select is combinational in the request cycle; epc/in_isr/int_enable are registered.
// Backpressure: stall holds the PC; redirects and erets seen under stall are parked and replayed when stall drops.
module pc_control #(
  parameter logic INT_EN_RESET = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  pc_control_if.master bus
);

  localparam logic [1:0] ST_BOOT      = 2'd0;
  localparam logic [1:0] ST_RUN       = 2'd1;
  localparam logic [1:0] ST_IRQ_ENTRY = 2'd2;
  localparam logic [1:0] ST_ISR       = 2'd3;

  localparam logic [1:0] SEL_RESET  = 2'b00;
  localparam logic [1:0] SEL_IRQ    = 2'b01;
  localparam logic [1:0] SEL_SEQ    = 2'b10;
  localparam logic [1:0] SEL_BRANCH = 2'b11;

  logic [1:0]  state, state_nxt;
  logic        pending, pending_nxt;
  logic        pending_eret, pending_eret_nxt;
  logic [31:0] pending_target, pending_target_nxt;
  logic [31:0] epc_q, epc_nxt;
  logic        in_isr_q, in_isr_nxt;
  logic        int_en_q, int_en_nxt;

  logic [1:0]  pc_sel_c;
  logic [31:0] pc_branch_c;
  logic        flush_c;

  logic        irq_accept;
  logic        eret_valid;
  logic [31:0] pc_inc;

  assign irq_accept = (state == ST_RUN) && int_en_q && !in_isr_q && !bus.stall && bus.irq;
  assign eret_valid = (state == ST_ISR) && bus.eret;
  assign pc_inc     = bus.pc + 32'd1;

  always_comb begin
    state_nxt          = state;
    pending_nxt        = pending;
    pending_eret_nxt   = pending_eret;
    pending_target_nxt = pending_target;
    epc_nxt            = epc_q;
    in_isr_nxt         = in_isr_q;
    int_en_nxt         = int_en_q;
    pc_sel_c           = SEL_SEQ;
    pc_branch_c        = 32'h0;
    flush_c            = 1'b0;

    case (state)
      ST_BOOT: begin
        pc_sel_c  = SEL_RESET;
        state_nxt = ST_RUN;
      end

      // Hold the vector select until fetch actually takes it.
      ST_IRQ_ENTRY: begin
        pc_sel_c         = SEL_IRQ;
        pending_nxt      = 1'b0;
        pending_eret_nxt = 1'b0;
        if (!bus.stall) begin
          flush_c    = 1'b1;
          state_nxt  = ST_ISR;
          in_isr_nxt = 1'b1;
          int_en_nxt = 1'b0;
        end
      end

      default: begin
        if (bus.stall) begin
          if (eret_valid) begin
            pending_nxt        = 1'b1;
            pending_eret_nxt   = 1'b1;
            pending_target_nxt = epc_q;
          end else if (bus.branch_taken) begin
            pending_nxt        = 1'b1;
            pending_eret_nxt   = 1'b0;
            pending_target_nxt = bus.branch_target;
          end
        end else if (irq_accept) begin
          // Return address is wherever the program would have gone next.
          state_nxt        = ST_IRQ_ENTRY;
          pending_nxt      = 1'b0;
          pending_eret_nxt = 1'b0;
          if (bus.branch_taken)
            epc_nxt = bus.branch_target;
          else if (pending)
            epc_nxt = pending_target;
          else
            epc_nxt = pc_inc;
        end else if (eret_valid) begin
          pc_sel_c         = SEL_BRANCH;
          pc_branch_c      = epc_q;
          flush_c          = 1'b1;
          pending_nxt      = 1'b0;
          pending_eret_nxt = 1'b0;
          state_nxt        = ST_RUN;
          in_isr_nxt       = 1'b0;
          int_en_nxt       = 1'b1;
        end else if (bus.branch_taken) begin
          pc_sel_c         = SEL_BRANCH;
          pc_branch_c      = bus.branch_target;
          flush_c          = 1'b1;
          pending_nxt      = 1'b0;
          pending_eret_nxt = 1'b0;
        end else if (pending) begin
          pc_sel_c         = SEL_BRANCH;
          pc_branch_c      = pending_target;
          flush_c          = 1'b1;
          pending_nxt      = 1'b0;
          pending_eret_nxt = 1'b0;
          if (pending_eret && (state == ST_ISR)) begin
            state_nxt  = ST_RUN;
            in_isr_nxt = 1'b0;
            int_en_nxt = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ST_BOOT;
      pending        <= 1'b0;
      pending_eret   <= 1'b0;
      pending_target <= 32'h0;
      epc_q          <= 32'h0;
      in_isr_q       <= 1'b0;
      int_en_q       <= INT_EN_RESET;
    end else begin
      state          <= state_nxt;
      pending        <= pending_nxt;
      pending_eret   <= pending_eret_nxt;
      pending_target <= pending_target_nxt;
      epc_q          <= epc_nxt;
      in_isr_q       <= in_isr_nxt;
      int_en_q       <= int_en_nxt;
    end
  end

  assign bus.pc_sel     = pc_sel_c;
  assign bus.pc_branch  = pc_branch_c;
  assign bus.flush      = flush_c;
  assign bus.epc        = epc_q;
  assign bus.in_isr     = in_isr_q;
  assign bus.int_enable = int_en_q;

  a_no_flush_on_stall: assert property (@(posedge clk) disable iff (reset)
    !(bus.flush && bus.stall));
  a_branch_zero_idle: assert property (@(posedge clk) disable iff (reset)
    (bus.pc_sel == SEL_BRANCH) || (bus.pc_branch == 32'h0));

endmodule

// File: tb/tb_pc_control.sv
// Scoreboard bench for pc_control: each driven cycle queues its expected outputs, checked at negedge.
module tb_pc_control;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  pc_control_if bus ();

  pc_control #(.INT_EN_RESET(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [1:0]  sel;
    logic [31:0] br;
    logic        fl;
    logic [31:0] epc;
    logic        isr;
    logic        ien;
  } exp_t;

  exp_t exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk({e.tag, ".pc_sel"},     {30'h0, bus.pc_sel},     {30'h0, e.sel});
      chk({e.tag, ".pc_branch"},  bus.pc_branch,           e.br);
      chk({e.tag, ".flush"},      {31'h0, bus.flush},      {31'h0, e.fl});
      chk({e.tag, ".epc"},        bus.epc,                 e.epc);
      chk({e.tag, ".in_isr"},     {31'h0, bus.in_isr},     {31'h0, e.isr});
      chk({e.tag, ".int_enable"}, {31'h0, bus.int_enable}, {31'h0, e.ien});
    end
  end

  task automatic drive_idle();
    bus.stall         = 1'b0;
    bus.pc            = 32'h0;
    bus.irq           = 1'b0;
    bus.branch_taken  = 1'b0;
    bus.branch_target = 32'h0;
    bus.eret          = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive_idle();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // One clock of stimulus plus the outputs expected during that same cycle.
  task automatic cyc(input string tag, input logic st, input logic [31:0] p, input logic iq,
                     input logic bt, input logic [31:0] tgt, input logic er,
                     input logic [1:0] e_sel, input logic [31:0] e_br, input logic e_fl,
                     input logic [31:0] e_epc, input logic e_isr, input logic e_ien);
    exp_t e;
    reset             = 1'b0;
    bus.stall         = st;
    bus.pc            = p;
    bus.irq           = iq;
    bus.branch_taken  = bt;
    bus.branch_target = tgt;
    bus.eret          = er;
    e.tag = tag; e.sel = e_sel; e.br = e_br; e.fl = e_fl;
    e.epc = e_epc; e.isr = e_isr; e.ien = e_ien;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    bad++;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    total = 0;
    bad   = 0;
    do_reset();

    // reset release then idle
    cyc("boot",  0, 32'h0,  0, 0, 32'h0, 0, 2'b00, 32'h0, 0, 32'h0, 0, 1);
    cyc("idle1", 0, 32'h1,  0, 0, 32'h0, 0, 2'b10, 32'h0, 0, 32'h0, 0, 1);
    cyc("idle2", 0, 32'h2,  0, 0, 32'h0, 0, 2'b10, 32'h0, 0, 32'h0, 0, 1);
    cyc("idle3", 0, 32'h3,  0, 0, 32'h0, 0, 2'b10, 32'h0, 0, 32'h0, 0, 1);

    // unstalled branch
    cyc("br40",  0, 32'h10, 0, 1, 32'h40, 0, 2'b11, 32'h40, 1, 32'h0, 0, 1);
    cyc("br40n", 0, 32'h40, 0, 0, 32'h0,  0, 2'b10, 32'h0,  0, 32'h0, 0, 1);

    // branch under stall is parked and replayed
    cyc("pb1",   1, 32'h41, 0, 1, 32'h80, 0, 2'b10, 32'h0,  0, 32'h0, 0, 1);
    cyc("pb2",   1, 32'h41, 0, 0, 32'h0,  0, 2'b10, 32'h0,  0, 32'h0, 0, 1);
    cyc("pb3",   1, 32'h41, 0, 0, 32'h0,  0, 2'b10, 32'h0,  0, 32'h0, 0, 1);
    cyc("pb4",   0, 32'h41, 0, 0, 32'h0,  0, 2'b11, 32'h80, 1, 32'h0, 0, 1);
    cyc("pb5",   0, 32'h80, 0, 0, 32'h0,  0, 2'b10, 32'h0,  0, 32'h0, 0, 1);

    // latest parked redirect wins; live branch beats parked one
    cyc("ow1",   1, 32'h81, 0, 1, 32'h84, 0, 2'b10, 32'h0,  0, 32'h0, 0, 1);
    cyc("ow2",   1, 32'h81, 0, 1, 32'h88, 0, 2'b10, 32'h0,  0, 32'h0, 0, 1);
    cyc("ow3",   0, 32'h81, 0, 0, 32'h0,  0, 2'b11, 32'h88, 1, 32'h0, 0, 1);
    cyc("lv1",   1, 32'h88, 0, 1, 32'h8A, 0, 2'b10, 32'h0,  0, 32'h0, 0, 1);
    cyc("lv2",   0, 32'h88, 0, 1, 32'h8C, 0, 2'b11, 32'h8C, 1, 32'h0, 0, 1);
    cyc("lv3",   0, 32'h8C, 0, 0, 32'h0,  0, 2'b10, 32'h0,  0, 32'h0, 0, 1);

    // interrupt entry
    cyc("irq",   0, 32'h20, 1, 0, 32'h0,  0, 2'b10, 32'h0,  0, 32'h0,  0, 1);
    cyc("ient",  0, 32'h21, 1, 0, 32'h0,  0, 2'b01, 32'h0,  1, 32'h21, 0, 1);
    cyc("isr",   0, 32'h100,1, 0, 32'h0,  0, 2'b10, 32'h0,  0, 32'h21, 1, 0);

    // eret with irq held, then irq re-accepted in RUN
    cyc("eret",  0, 32'h101,1, 0, 32'h0,  1, 2'b11, 32'h21, 1, 32'h21, 1, 0);
    cyc("reirq", 0, 32'h30, 1, 0, 32'h0,  0, 2'b10, 32'h0,  0, 32'h21, 0, 1);
    cyc("rient", 0, 32'h31, 0, 0, 32'h0,  0, 2'b01, 32'h0,  1, 32'h31, 0, 1);
    cyc("risr",  0, 32'h100,0, 0, 32'h0,  0, 2'b10, 32'h0,  0, 32'h31, 1, 0);

    // eret under stall is parked; exit happens on replay
    cyc("pe1",   1, 32'h101,0, 0, 32'h0,  1, 2'b10, 32'h0,  0, 32'h31, 1, 0);
    cyc("pe2",   1, 32'h101,0, 0, 32'h0,  0, 2'b10, 32'h0,  0, 32'h31, 1, 0);
    cyc("pe3",   0, 32'h101,0, 0, 32'h0,  0, 2'b11, 32'h31, 1, 32'h31, 1, 0);
    cyc("pe4",   0, 32'h31, 0, 0, 32'h0,  0, 2'b10, 32'h0,  0, 32'h31, 0, 1);
    cyc("erun",  0, 32'h32, 0, 0, 32'h0,  1, 2'b10, 32'h0,  0, 32'h31, 0, 1);

    // irq beats a same-cycle branch; branch target becomes epc
    cyc("ib",    0, 32'h50, 1, 1, 32'h90, 0, 2'b10, 32'h0,  0, 32'h31, 0, 1);
    cyc("ibent", 0, 32'h51, 0, 0, 32'h0,  0, 2'b01, 32'h0,  1, 32'h90, 0, 1);
    cyc("ibisr", 0, 32'h100,0, 0, 32'h0,  0, 2'b10, 32'h0,  0, 32'h90, 1, 0);
    cyc("isrbr", 0, 32'h101,0, 1, 32'hA0, 0, 2'b11, 32'hA0, 1, 32'h90, 1, 0);
    cyc("isrirq",0, 32'hA0, 1, 0, 32'h0,  0, 2'b10, 32'h0,  0, 32'h90, 1, 0);

    // reset mid-ISR with a parked redirect
    cyc("rp",    1, 32'hA1, 0, 1, 32'hB0, 0, 2'b10, 32'h0,  0, 32'h90, 1, 0);
    do_reset();
    cyc("rboot", 0, 32'h0,  0, 0, 32'h0,  0, 2'b00, 32'h0,  0, 32'h0, 0, 1);
    cyc("rrun",  0, 32'h1,  0, 0, 32'h0,  0, 2'b10, 32'h0,  0, 32'h0, 0, 1);

    // stall ignored in BOOT
    do_reset();
    cyc("sboot", 1, 32'h0,  0, 0, 32'h0,  0, 2'b00, 32'h0,  0, 32'h0, 0, 1);
    cyc("srun",  1, 32'h1,  0, 0, 32'h0,  0, 2'b10, 32'h0,  0, 32'h0, 0, 1);

    // parked redirect becomes epc when irq wins
    cyc("pi1",   1, 32'h60, 0, 1, 32'hC0, 0, 2'b10, 32'h0,  0, 32'h0,  0, 1);
    cyc("pi2",   0, 32'h60, 1, 0, 32'h0,  0, 2'b10, 32'h0,  0, 32'h0,  0, 1);
    cyc("pi3",   0, 32'h61, 0, 0, 32'h0,  0, 2'b01, 32'h0,  1, 32'hC0, 0, 1);
    cyc("pi4",   0, 32'h100,0, 0, 32'h0,  0, 2'b10, 32'h0,  0, 32'hC0, 1, 0);
    cyc("pi5",   0, 32'h101,0, 0, 32'h0,  0, 2'b10, 32'h0,  0, 32'hC0, 1, 0);
    cyc("pi6",   0, 32'h102,0, 0, 32'h0,  1, 2'b11, 32'hC0, 1, 32'hC0, 1, 0);
    cyc("pi7",   0, 32'hC0, 0, 0, 32'h0,  0, 2'b10, 32'h0,  0, 32'hC0, 0, 1);

    // pc+1 wraps
    cyc("wr1",   0, 32'hFFFFFFFF, 1, 0, 32'h0, 0, 2'b10, 32'h0, 0, 32'hC0, 0, 1);
    cyc("wr2",   0, 32'h0,  0, 0, 32'h0,  0, 2'b01, 32'h0,  1, 32'h0,  0, 1);
    cyc("wr3",   0, 32'h100,0, 0, 32'h0,  0, 2'b10, 32'h0,  0, 32'h0,  1, 0);
    cyc("wr4",   0, 32'h101,0, 0, 32'h0,  1, 2'b11, 32'h0,  1, 32'h0,  1, 0);
    cyc("wr5",   0, 32'h0,  0, 0, 32'h0,  0, 2'b10, 32'h0,  0, 32'h0,  0, 1);

    @(negedge clk);
    chk("drain", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_control.md
PC_CONTROL -- requirements
Module: pc_control

Interface
REQ-001 Parameter INT_EN_RESET, default 1'b1: value loaded into int_enable on reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 stall  input  1  fetch hold; the same signal also drives the fetch stage PC enable.
REQ-005 pc  input  32  current fetch PC, word-addressed.
REQ-006 irq  input  1  level-sensitive interrupt request.
REQ-007 branch_taken  input  1  single-cycle redirect request from decode/execute.
REQ-008 branch_target  input  32  word address of the redirect; valid while branch_taken=1.
REQ-009 eret  input  1  single-cycle return-from-interrupt request.
REQ-010 pc_sel  output  2  fetch mux select: 00 reset addr, 01 interrupt addr, 10 pc+1, 11 pc_branch.
REQ-011 pc_branch  output  32  redirect address presented to fetch.
REQ-012 flush  output  1  squash the instruction currently in IF/ID.
REQ-013 epc  output  32  saved return address.
REQ-014 int_enable  output  1  interrupt acceptance enabled.
REQ-015 in_isr  output  1  high from interrupt entry until eret is taken.

Function
REQ-016 The FSM SHALL have four states: BOOT, RUN, IRQ_ENTRY and ISR.
REQ-017 BOOT: pc_sel=00 for exactly one cycle, then next state RUN; stall has no effect in BOOT.
REQ-018 RUN, default (no event, no pending redirect): pc_sel=10, flush=0.
REQ-019 Priority within RUN/ISR when stall=0: accepted irq > eret > branch_taken > pending redirect > sequential.
REQ-020 irq is accepted only when state=RUN, int_enable=1, in_isr=0 and stall=0.
REQ-021 Accepted irq: next state IRQ_ENTRY; epc captured in the same cycle.
REQ-022 epc capture value: branch_target if branch_taken=1; else the pending target if a redirect is pending; else pc+1 (mod 2^32).
REQ-023 IRQ_ENTRY: pc_sel=01 and flush=1 for one cycle, any pending redirect cleared, then next state ISR with in_isr=1 and int_enable=0.
REQ-024 ISR: sequential and branch behaviour identical to RUN; irq is ignored.
REQ-025 eret accepted in ISR with stall=0: pc_branch=epc, pc_sel=11, flush=1, in_isr<=0, int_enable<=1, next state RUN.
REQ-026 eret in RUN SHALL be ignored.
REQ-027 branch_taken with stall=0: pc_branch=branch_target, pc_sel=11, flush=1 in the same cycle (combinational).
REQ-028 branch_taken with stall=1: target latched into a pending register, pending<=1, pc_sel=10 (PC held by stall), flush=0.
REQ-029 On the first cycle with stall=0 and pending=1: pc_sel=11, pc_branch=pending target, flush=1, pending<=0.
REQ-030 A new branch_taken while pending=1 SHALL overwrite the pending target (the latest redirect wins).
REQ-031 An eret taken while stall=1 SHALL be latched as pending with target epc, following the same rules as REQ-028 and REQ-029; the ISR exit takes effect when the latched eret is applied.
REQ-032 pc_branch SHALL be 32'h0 whenever pc_sel is not 11.
REQ-033 flush SHALL never be asserted while stall=1.

Reset
REQ-034 reset=1 on a clock edge SHALL produce: state=BOOT, pending=0, epc=0, in_isr=0, int_enable=INT_EN_RESET.
REQ-035 In the cycle after reset: pc_sel=00, flush=0, pc_branch=0.
REQ-036 reset asserted mid-ISR or mid-pending SHALL discard all saved state with no residual redirect.

Verification
REQ-037 Reset release, then 3 idle cycles -> pc_sel sequence 00,10,10,10; flush=0 throughout.
REQ-038 pc=0x10, branch_taken=1, branch_target=0x40, stall=0 -> same cycle: pc_sel=11, pc_branch=0x40, flush=1.
REQ-039 stall=1 for 3 cycles, branch_taken pulses in cycle 1 with target 0x80, stall drops in cycle 4 -> cycles 1-3: pc_sel=10, flush=0; cycle 4: pc_sel=11, pc_branch=0x80, flush=1.
REQ-040 RUN, pc=0x20, irq=1 -> next cycle: pc_sel=01, flush=1, epc=0x21; following cycle: in_isr=1, int_enable=0.
REQ-041 In ISR, irq held high, eret=1 -> pc_sel=11, pc_branch=0x21; next cycle: in_isr=0, int_enable=1; irq accepted again once in RUN.
REQ-042 irq and branch_taken (target 0x90) in the same cycle -> epc=0x90; entry to 0x100 via pc_sel=01; no branch redirect issued.
